wb_cmd_exec: RTL and testbench
==============================

# wb_cmd_exec

Downstream command execution stage for the a2node command path. It consumes the two queued command words produced by the node's command queue and arbitrates between them. Each selected command runs as a single Wishbone classic transaction on the outbound bus. The block returns taken and complete strobes to the queue, and returns read data and status to the core side.

## Interface
- `TIMEOUT`, default 255: cycles in BUS without ack/err before forced error completion; 0 disables the timeout.
- `CMD_W`, default `CMD_SIZE`: command word width, from `defs.v`.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_in_0  in  CMD_W  queued command slot 0, using the `defs.v` field layout (`CMD_VALID`, `CMD_TAKEN`, `CMD_WE`, `CMD_SEL`, `CMD_ADR`, `CMD_DATW`)
- cmd_in_1  in  CMD_W  queued command slot 1
- cmd_taken  out  2  one-cycle pulse per slot when its command is issued on the bus
- cmd_complete  out  2  one-cycle pulse per slot when its transaction ends
- wb_cyc, wb_stb  out  1  Wishbone cycle and strobe
- wb_we  out  1  write enable
- wb_sel  out  4  byte selects
- wb_adr  out  32  address
- wb_datw  out  32  write data
- wb_ack  in  1  transaction acknowledge
- wb_err  in  1  transaction error
- wb_datr  in  32  read data
- rsp_valid  out  2  one-cycle response pulse per slot, coincident with cmd_complete
- rsp_err  out  1  response status, qualified by rsp_valid
- rsp_datr  out  32  read data, qualified by rsp_valid; 0 for writes and errors

## Operation
- A slot is eligible when `CMD_VALID`=1 and `CMD_TAKEN`=0.
- States:
  - IDLE → BUS: when an eligible slot exists.
  - BUS → DONE: on wb_err, on wb_ack, or when the timeout counter reaches TIMEOUT.
  - DONE → IDLE: unconditionally after one cycle.
- Grant, in IDLE:
  - If one slot is eligible, it is granted.
  - If both are eligible, the slot not served last is granted.
  - The last-served pointer resets to 0, so slot 1 wins the first tie.
- At grant, the slot index and the command's `CMD_WE`/`CMD_SEL`/`CMD_ADR`/`CMD_DATW` fields are latched into local registers.
  - The bus is driven only from these registers.
  - Input changes during BUS or DONE are ignored.
- BUS:
  - wb_cyc=wb_stb=1 for the whole state.
  - cmd_taken[grant] pulses in the first BUS cycle only.
  - The timeout counter is 8 bits wide, clears on entry, and increments each BUS cycle without ack/err.
- Completion priority, evaluated in the same cycle: wb_err > wb_ack > timeout.
  - Error or timeout: rsp_err=1, rsp_datr=0.
  - Read ack: rsp_datr is captured from wb_datr on the ack cycle.
- DONE:
  - wb_cyc=wb_stb=0.
  - cmd_complete[grant] and rsp_valid[grant] pulse.
  - The last-served pointer updates to the granted slot.
- No grant is made in DONE.
  - The upstream queue clears `CMD_VALID` on the edge after complete, so the same command is never reissued.
- wb_ack and wb_err are ignored outside BUS.
- Reset, including mid-transaction:
  - Next cycle: state IDLE, all outputs 0, pointer 0.
  - No complete is issued for the aborted command.

## Timing
- Reset values: wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_datw, cmd_taken, cmd_complete, rsp_valid, rsp_err and rsp_datr are all 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Eligible command seen in cycle 0 → wb_cyc/wb_stb and cmd_taken in cycle 1.
- wb_ack in BUS cycle k → cmd_complete and rsp_valid in cycle k+1 → IDLE in cycle k+2.
- Zero-wait-state slave: command visible in cycle 0, complete in cycle 2, next grant seen in cycle 3, next wb_cyc in cycle 4.
- Timeout with TIMEOUT=N: error completion N+1 cycles after wb_cyc rises.

## Structure
- Add to `defs.v`:
  - state encodings `WBX_ST_IDLE`, `WBX_ST_BUS`, `WBX_ST_DONE`;
  - `WBX_TIMEOUT_DEF`=255.
- Command field macros are reused unchanged.
- One sub-module: `wb_rr_arb2`, a 2-request round-robin arbiter.
  - Inputs: req[1:0], last pointer.
  - Outputs: gnt one-hot, gnt_idx.
  - Purely combinational; the pointer register stays in `wb_cmd_exec`.

## Test plan
- Slot 1 write, adr 0x1000, sel 0xF, datw 0xDEADBEEF, zero-wait ack:
  - cmd_taken=2'b10 in cycle 1, bus fields match the command;
  - cmd_complete=rsp_valid=2'b10 in cycle 2, rsp_err=0, rsp_datr=0.
- Slot 0 read, adr 0x2000, ack after 3 wait states with wb_datr=0x12345678:
  - rsp_datr=0x12345678 in the cycle after ack;
  - wb_cyc high for exactly 4 cycles.
- Both slots eligible after reset:
  - slot 1 is issued first, then slot 0;
  - re-arm both, and slot 1 again follows slot 0 (alternation).
- TIMEOUT=4 with no ack:
  - wb_cyc high for 5 cycles;
  - then cmd_complete with rsp_err=1, rsp_datr=0.
- wb_ack and wb_err together → rsp_err=1.
- rst asserted in the second BUS cycle → wb_cyc=0 next cycle and no cmd_complete pulse.

Source files
------------

// File: rtl/wb_cmd_exec_pkg.sv
// Shared types for the command execution stage: command word layout, FSM states, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_cmd_exec_pkg;

    // Command word as produced by the node command queue, MSB first.
    typedef struct packed {
        logic [31:0] datw;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic        taken;
        logic        valid;
    } cmd_t;

    localparam int CMD_SIZE        = $bits(cmd_t);
    localparam int WBX_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        WBX_ST_IDLE = 2'd0,
        WBX_ST_BUS  = 2'd1,
        WBX_ST_DONE = 2'd2
    } wbx_state_t;

    // A slot may be issued only while it is queued and not yet handed to the bus.
    function automatic logic cmd_eligible(input cmd_t c);
        return c.valid && !c.taken;
    endfunction

endpackage

// File: rtl/wb_cmd_exec_if.sv
// Outbound Wishbone classic bus bundle between the execution stage and the slave.
// Latency: n/a (wires only).
// Backpressure: slave stalls the master by withholding wb_ack/wb_err.
interface wb_cmd_exec_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_datw;
    logic        wb_ack;
    logic        wb_err;
    logic [31:0] wb_datr;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_datw,
        input  wb_ack, wb_err, wb_datr
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_datw,
        output wb_ack, wb_err, wb_datr
    );
endinterface

// File: rtl/wb_rr_arb2.sv
// Two-request round-robin arbiter; a tie goes to the slot that was not served last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module wb_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    // Single requester wins outright; on a tie the pointer picks the other slot.
    always_comb begin
        gnt     = 2'b00;
        gnt_idx = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = ~last;
            gnt     = last ? 2'b01 : 2'b10;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
            gnt     = 2'b10;
        end else if (req[0]) begin
            gnt     = 2'b01;
        end
    end

endmodule

// File: rtl/wb_cmd_exec.sv
// Issues queued command slots as single Wishbone classic transactions, round-robin between slots.
// Latency: eligible cmd -> wb_cyc next cycle; ack in cycle k -> complete/rsp in k+1, idle in k+2.
// Backpressure: holds one command in BUS until ack/err/timeout; new grants only from IDLE.
module wb_cmd_exec
    import wb_cmd_exec_pkg::*;
#(
    parameter int TIMEOUT = WBX_TIMEOUT_DEF,
    parameter int CMD_W   = CMD_SIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CMD_W-1:0]   cmd_in_0,
    input  logic [CMD_W-1:0]   cmd_in_1,
    output logic [1:0]         cmd_taken,
    output logic [1:0]         cmd_complete,
    wb_cmd_exec_if.master      wb,
    output logic [1:0]         rsp_valid,
    output logic               rsp_err,
    output logic [31:0]        rsp_datr
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    cmd_t       cmd_0;
    cmd_t       cmd_1;
    wbx_state_t state;
    logic       last_srv;
    logic       slot;
    logic [7:0] tmo_cnt;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       gnt_idx;
    logic       tmo_hit;
    cmd_t       gnt_cmd;

    assign cmd_0   = cmd_in_0;
    assign cmd_1   = cmd_in_1;
    assign req     = {cmd_eligible(cmd_1), cmd_eligible(cmd_0)};
    assign gnt_cmd = gnt_idx ? cmd_1 : cmd_0;
    // A zero TIMEOUT means the bus may stall forever.
    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LIMIT);

    wb_rr_arb2 u_arb (
        .req     (req),
        .last    (last_srv),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Transaction FSM; every output is a register so nothing from the inputs leaks through.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WBX_ST_IDLE;
            last_srv     <= 1'b0;
            slot         <= 1'b0;
            tmo_cnt      <= 8'd0;
            cmd_taken    <= 2'b00;
            cmd_complete <= 2'b00;
            rsp_valid    <= 2'b00;
            rsp_err      <= 1'b0;
            rsp_datr     <= 32'd0;
            wb.wb_cyc    <= 1'b0;
            wb.wb_stb    <= 1'b0;
            wb.wb_we     <= 1'b0;
            wb.wb_sel    <= 4'd0;
            wb.wb_adr    <= 32'd0;
            wb.wb_datw   <= 32'd0;
        end else begin
            cmd_taken    <= 2'b00;
            cmd_complete <= 2'b00;
            rsp_valid    <= 2'b00;
            case (state)
                WBX_ST_IDLE: begin
                    if (|gnt) begin
                        // Latch the granted command; the bus only ever sees these copies.
                        slot       <= gnt_idx;
                        wb.wb_we   <= gnt_cmd.we;
                        wb.wb_sel  <= gnt_cmd.sel;
                        wb.wb_adr  <= gnt_cmd.adr;
                        wb.wb_datw <= gnt_cmd.datw;
                        wb.wb_cyc  <= 1'b1;
                        wb.wb_stb  <= 1'b1;
                        cmd_taken  <= gnt;
                        tmo_cnt    <= 8'd0;
                        state      <= WBX_ST_BUS;
                    end
                end
                WBX_ST_BUS: begin
                    if (wb.wb_err || wb.wb_ack || tmo_hit) begin
                        // err beats ack beats timeout; only a clean read ack returns data.
                        wb.wb_cyc    <= 1'b0;
                        wb.wb_stb    <= 1'b0;
                        cmd_complete <= slot ? 2'b10 : 2'b01;
                        rsp_valid    <= slot ? 2'b10 : 2'b01;
                        rsp_err      <= wb.wb_err || !wb.wb_ack;
                        rsp_datr     <= (!wb.wb_err && wb.wb_ack && !wb.wb_we) ? wb.wb_datr : 32'd0;
                        last_srv     <= slot;
                        state        <= WBX_ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                WBX_ST_DONE: begin
                    // One dead cycle lets the queue retire the completed slot before re-arbitration.
                    state <= WBX_ST_IDLE;
                end
                default: begin
                    state <= WBX_ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_exec.sv
// Self-checking bench: acts as command queue and Wishbone slave around wb_cmd_exec.
// Latency: n/a.
// Backpressure: slave inserts random wait states, errors and timeouts.
module tb_wb_cmd_exec;
    import wb_cmd_exec_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    cmd_t        cmd0;
    cmd_t        cmd1;
    logic [1:0]  cmd_taken;
    logic [1:0]  cmd_complete;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_datr;

    int total = 0;
    int bad   = 0;
    int last_srv = 0;

    wb_cmd_exec_if wb ();

    wb_cmd_exec #(.TIMEOUT(TMO), .CMD_W(CMD_SIZE)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_in_0     (cmd0),
        .cmd_in_1     (cmd1),
        .cmd_taken    (cmd_taken),
        .cmd_complete (cmd_complete),
        .wb           (wb),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_datr     (rsp_datr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random activity on slave lines that the DUT must ignore outside BUS.
    task automatic noise();
        wb.wb_ack  = 1'($urandom);
        wb.wb_err  = 1'($urandom);
        wb.wb_datr = $urandom;
    endtask

    function automatic cmd_t mk_cmd(input logic we, input logic [3:0] sel,
                                    input logic [31:0] adr, input logic [31:0] datw);
        cmd_t c;
        c.valid = 1'b1;
        c.taken = 1'b0;
        c.we    = we;
        c.sel   = sel;
        c.adr   = adr;
        c.datw  = datw;
        return c;
    endfunction

    // Reference arbitration: lone eligible slot wins, a tie goes to the slot not served last.
    function automatic int model_pick();
        bit e0;
        bit e1;
        e0 = cmd0.valid && !cmd0.taken;
        e1 = cmd1.valid && !cmd1.taken;
        if (e0 && e1) return 1 - last_srv;
        return e1 ? 1 : 0;
    endfunction

    // One whole transaction for `slot`: bus cycle appears after `lead` cycles,
    // slave answers in bus cycle waits+1 (waits<0: never, so the timeout fires).
    task automatic run_txn(input int slot, input int lead, input int waits,
                           input bit use_err, input bit use_both, input logic [31:0] rd);
        cmd_t        c;
        logic [1:0]  oh;
        int          n;
        int          exp_len;
        logic        exp_err;
        logic [31:0] exp_datr;
        c        = (slot == 1) ? cmd1 : cmd0;
        oh       = (slot == 1) ? 2'b10 : 2'b01;
        exp_len  = (waits < 0) ? TMO + 1 : waits + 1;
        exp_err  = (waits < 0) || use_err;
        exp_datr = 32'd0;
        for (int i = 0; i < lead - 1; i++) begin
            step();
            chk("idle_cyc", wb.wb_cyc, 0);
            noise();
        end
        step();
        n = 0;
        while (wb.wb_cyc === 1'b1 && n < 300) begin
            n++;
            chk("stb", wb.wb_stb, 1);
            chk("we", wb.wb_we, c.we);
            chk("sel", wb.wb_sel, c.sel);
            chk("adr", wb.wb_adr, c.adr);
            chk("datw", wb.wb_datw, c.datw);
            chk("taken", cmd_taken, (n == 1) ? oh : 2'b00);
            chk("cmpl_early", cmd_complete, 0);
            if (n == 1) begin
                if (slot == 1) cmd1.taken = 1'b1; else cmd0.taken = 1'b1;
            end else if (slot == 1) begin
                cmd1.adr = $urandom; cmd1.datw = $urandom; cmd1.we = ~cmd1.we;
            end else begin
                cmd0.adr = $urandom; cmd0.datw = $urandom; cmd0.we = ~cmd0.we;
            end
            wb.wb_ack  = 1'b0;
            wb.wb_err  = 1'b0;
            wb.wb_datr = $urandom;
            if (waits >= 0 && n == waits + 1) begin
                if (use_err) begin
                    wb.wb_err = 1'b1;
                    wb.wb_ack = use_both;
                end else begin
                    wb.wb_ack  = 1'b1;
                    wb.wb_datr = rd;
                    if (!c.we) exp_datr = rd;
                end
            end
            step();
        end
        chk("bus_len", n, exp_len);
        chk("cyc_done", wb.wb_cyc, 0);
        chk("complete", cmd_complete, oh);
        chk("rsp_valid", rsp_valid, oh);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_datr", rsp_datr, exp_datr);
        if (slot == 1) cmd1.valid = 1'b0; else cmd0.valid = 1'b0;
        last_srv = slot;
        noise();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        wb.wb_ack  = 1'b0;
        wb.wb_err  = 1'b0;
        wb.wb_datr = 32'd0;
        step();
        step();
        last_srv = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lead;
        int waits;
        cmd0 = '0;
        cmd1 = '0;
        do_reset();
        chk("rst_cyc", wb.wb_cyc, 0);
        chk("rst_stb", wb.wb_stb, 0);
        chk("rst_we", wb.wb_we, 0);
        chk("rst_sel", wb.wb_sel, 0);
        chk("rst_adr", wb.wb_adr, 0);
        chk("rst_datw", wb.wb_datw, 0);
        chk("rst_taken", cmd_taken, 0);
        chk("rst_cmpl", cmd_complete, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_rsperr", rsp_err, 0);
        chk("rst_rspdat", rsp_datr, 0);

        // Slot 1 zero-wait write.
        rst  = 1'b0;
        cmd1 = mk_cmd(1'b1, 4'hF, 32'h1000, 32'hDEADBEEF);
        run_txn(1, 1, 0, 0, 0, 32'h0);

        // Slot 0 read with three wait states.
        cmd0 = mk_cmd(1'b0, 4'hF, 32'h2000, 32'h0);
        run_txn(0, 2, 3, 0, 0, 32'h12345678);

        // Tie after reset: slot 1 first, then slot 0, then alternation continues.
        do_reset();
        rst  = 1'b0;
        cmd0 = mk_cmd(1'b0, 4'h3, 32'h3000, 32'h0);
        cmd1 = mk_cmd(1'b1, 4'hC, 32'h3100, 32'hA5A5A5A5);
        run_txn(1, 1, 1, 0, 0, 32'h0);
        run_txn(0, 2, 0, 0, 0, 32'hCAFEF00D);
        cmd0 = mk_cmd(1'b1, 4'h1, 32'h3200, 32'h11112222);
        cmd1 = mk_cmd(1'b0, 4'h8, 32'h3300, 32'h0);
        run_txn(1, 2, 2, 0, 0, 32'h0BADC0DE);
        run_txn(0, 2, 0, 0, 0, 32'h0);

        // No response: timeout error.
        cmd0 = mk_cmd(1'b0, 4'hF, 32'h4000, 32'h0);
        run_txn(0, 2, -1, 0, 0, 32'h0);

        // ack and err together on a read.
        cmd1 = mk_cmd(1'b0, 4'hF, 32'h5000, 32'h0);
        run_txn(1, 2, 1, 1, 1, 32'h77777777);

        // Reset in the second bus cycle aborts without a completion.
        cmd0       = mk_cmd(1'b1, 4'hF, 32'h6000, 32'h12121212);
        wb.wb_ack  = 1'b0;
        wb.wb_err  = 1'b0;
        step();
        chk("abort_idle", wb.wb_cyc, 0);
        step();
        chk("abort_bus1", wb.wb_cyc, 1);
        step();
        chk("abort_bus2", wb.wb_cyc, 1);
        rst = 1'b1;
        step();
        chk("abort_cyc", wb.wb_cyc, 0);
        chk("abort_cmpl", cmd_complete, 0);
        chk("abort_rspv", rsp_valid, 0);
        rst        = 1'b0;
        cmd0.valid = 1'b0;
        last_srv   = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_quiet_cmpl", cmd_complete, 0);
            chk("abort_quiet_cyc", wb.wb_cyc, 0);
        end

        // Randomized traffic against the arbitration model.
        lead = 1;
        for (int it = 0; it < 60; it++) begin
            if (!cmd0.valid && ($urandom_range(0, 1) == 1))
                cmd0 = mk_cmd(1'($urandom), 4'($urandom), $urandom, $urandom);
            if (!cmd1.valid && ($urandom_range(0, 1) == 1))
                cmd1 = mk_cmd(1'($urandom), 4'($urandom), $urandom, $urandom);
            if (!cmd0.valid && !cmd1.valid)
                cmd0 = mk_cmd(1'($urandom), 4'($urandom), $urandom, $urandom);
            waits = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TMO));
            run_txn(model_pick(), lead, waits, ($urandom_range(0, 4) == 0),
                    1'($urandom), $urandom);
            lead = 2;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
